// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC owner: single-outstanding imem reads into a small in-order buffer feeding decode.
// Optional misaligned-redirect fault enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, FAULT} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   addr_n;
  logic          req_n;
  logic [CW-1:0] count, count_n, count_pop;
  logic [IW-1:0] push_idx;
  logic [31:0]   instr_q [BUF_DEPTH];
  logic [31:0]   pc_q    [BUF_DEPTH];
  logic [31:0]   instr_n [BUF_DEPTH];
  logic [31:0]   pc_n    [BUF_DEPTH];
  logic          ack, pop, push, flush, misaligned;
  logic [31:0]   target;

  assign ack       = imem_req && imem_ack;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign count_pop = count - CW'(pop);
  assign push_idx  = count_pop[IW-1:0];

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign fault      = (state == FAULT);
`else
  assign target     = redirect_pc & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  assign out_valid = (count != '0);
  assign out_instr = instr_q[0];
  assign out_pc    = pc_q[0];
  assign out_pc_4  = pc_q[0] + 32'd4;

  // imem_req is registered, so a request decided at an edge appears the following cycle
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_n      = imem_req;
    addr_n     = imem_addr;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = fetch_pc;
      end
      FETCH: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_n = target;
          if (misaligned) begin
            state_n = FAULT;
            req_n   = imem_req && !imem_ack;
          end else if (imem_req && !imem_ack) begin
            state_n = DISCARD;
          end else begin
            req_n  = 1'b1;
            addr_n = target;
          end
        end else if (imem_req) begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_n = imem_addr + 32'd4;
            req_n      = 1'b0;
          end
        end else if (count_pop < CW'(BUF_DEPTH)) begin
          req_n  = 1'b1;
          addr_n = fetch_pc;
        end
      end
      DISCARD: begin
        // the held request's response belongs to the old path and is dropped
        if (redirect_valid) begin
          fetch_pc_n = target;
        end
        if (ack) begin
          req_n = 1'b0;
        end
        if (redirect_valid && misaligned) begin
          state_n = FAULT;
        end else if (ack) begin
          state_n = FETCH;
        end
      end
      FAULT: begin
        flush = 1'b1;
        if (ack) begin
          req_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    instr_n = instr_q;
    pc_n    = pc_q;
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          instr_n[i] = instr_q[i+1];
          pc_n[i]    = pc_q[i+1];
        end
      end
      if (push) begin
        instr_n[push_idx] = imem_rdata;
        pc_n[push_idx]    = imem_addr;
        count_n           = count_pop + CW'(1);
      end else begin
        count_n = count_pop;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      count     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      count     <= count_n;
      instr_q   <= instr_n;
      pc_q      <= pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: latency-randomised memory model plus an
// expected-stream scoreboard of {instr, pc} words that decode should see.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault;
`endif

  fetch_pc_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_4(out_pc_4)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  int          checks = 0;
  int          errors = 0;
  entry_t      model_q[$];
  logic [31:0] acked_addr[$];
  logic [31:0] exp_pc;
  bit          busy, discarding, faulted;
  int          age, cur_lat, lat_lo, lat_hi, pops;
  bit          prev_req, prev_ack;
  logic [31:0] prev_addr;

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit starting();
    return imem_req && !busy;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_pc     = RESET_PC;
    busy       = 1'b0;
    discarding = 1'b0;
    faulted    = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = '0;
  endtask

  // One cycle: check outputs at the negedge, drive inputs, advance the model, wait a cycle
  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          ack, pop;
    logic [31:0] target;
    checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkOutput("out_instr", out_instr, model_q[0].instr);
      checkOutput("out_pc", out_pc, model_q[0].pc);
      checkOutput("out_pc_4", out_pc_4, model_q[0].pc + 32'd4);
    end
    if (prev_req && !prev_ack) begin
      checkOutput("req_hold", 32'(imem_req), 32'd1);
      checkOutput("addr_hold", imem_addr, prev_addr);
    end
    ack = 1'b0;
    if (imem_req) begin
      if (!busy) begin
        busy    = 1'b1;
        age     = 0;
        cur_lat = $urandom_range(lat_hi, lat_lo);
        checkOutput("req_room", 32'(model_q.size() < BUF_DEPTH), 32'd1);
      end
      ack = (age >= cur_lat);
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    imem_ack       = ack;
    imem_rdata     = ack ? mem_word(imem_addr) : $urandom();
`ifdef FETCH_ALIGN_CHECK_EN
    target = rpc;
`else
    target = {rpc[31:2], 2'b00};
`endif
    pop = (model_q.size() != 0) && rdy && !rv;
    if (pop) begin
      void'(model_q.pop_front());
      pops++;
    end
    if (ack) begin
      busy = 1'b0;
      if (!rv && !discarding && !faulted) begin
        checkOutput("fetch_addr", imem_addr, exp_pc);
        model_q.push_back('{mem_word(exp_pc), exp_pc});
        acked_addr.push_back(imem_addr);
        exp_pc = exp_pc + 32'd4;
      end
      discarding = 1'b0;
    end else if (busy) begin
      age++;
    end
    if (rv) begin
      model_q.delete();
      exp_pc = target;
`ifdef FETCH_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) faulted = 1'b1;
`endif
      if (imem_req && !ack) discarding = 1'b1;
    end
    prev_req  = imem_req;
    prev_ack  = ack;
    prev_addr = imem_addr;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int          k, start_size, start_acks, pops0;
    bit          found, seen;
    logic [31:0] rpc;

    model_reset();
    pops   = 0;
    lat_lo = 0;
    lat_hi = 0;
    repeat (3) @(negedge clk);

    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_instr", out_instr, 32'd0);
    checkOutput("rst_pc", out_pc, 32'd0);
    checkOutput("rst_pc_4", out_pc_4, 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("rst_fault", 32'(fault), 32'd0);
`endif

    // Start-up with zero-wait memory
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("start_req", 32'(imem_req), 32'd1);
    checkOutput("start_addr", imem_addr, RESET_PC);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_pc", out_pc, RESET_PC);
    checkOutput("lat_pc_4", out_pc_4, RESET_PC + 32'd4);
    repeat (6) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++)
      checkOutput("start_seq", (i < acked_addr.size()) ? acked_addr[i] : 32'hxxxx_xxxx,
                  RESET_PC + 32'(4 * i));

    // Backpressure: buffer fills to exactly BUF_DEPTH and requests stop
    lat_hi     = 1;
    start_size = model_q.size();
    start_acks = acked_addr.size();
    repeat (10) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("bp_acks", 32'(acked_addr.size() - start_acks), 32'(BUF_DEPTH - start_size));
    checkOutput("bp_full", 32'(out_valid), 32'd1);
    repeat (3) begin
      checkOutput("bp_no_req", 32'(imem_req), 32'd0);
      applyStimulus(1'b0, '0, 1'b0);
    end
    pops0 = pops;
    repeat (20) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_drain", 32'(pops - pops0 >= BUF_DEPTH), 32'd1);

    // Redirect while a slow request is outstanding
    lat_hi = 0;
    for (int i = 0; i < 10 && imem_req; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t4_idle", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1);
    checkOutput("redir_next_req", 32'(imem_req), 32'd1);
    checkOutput("redir_next_addr", imem_addr, 32'h0000_0100);
    lat_lo = 3;
    lat_hi = 3;
    found  = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (starting() && imem_addr === 32'h0000_0108) found = 1'b1;
      else applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("t4_found_108", 32'(found), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'h0000_2000, 1'b1);
    lat_lo = 0;
    lat_hi = 0;
    for (int i = 0; i < 20 && !starting(); i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t4_next_addr", imem_addr, 32'h0000_2000);
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t4_first_pc", out_pc, 32'h0000_2000);

    // Redirect coinciding with ack and pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && out_valid) found = 1'b1;
      else applyStimulus(1'b0, '0, 1'b0);
    end
    checkOutput("t5_found", 32'(found), 32'd1);
    applyStimulus(1'b1, 32'h0000_0040, 1'b1);
    checkOutput("t5_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_req", 32'(imem_req), 32'd1);
    checkOutput("t5_addr", imem_addr, 32'h0000_0040);

    // Wrap-around of the fetch PC
    lat_hi = 1;
    k = acked_addr.size();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && acked_addr.size() < k + 2; i++) begin
      if (out_valid && out_pc === 32'hFFFF_FFFC && !seen) begin
        seen = 1'b1;
        checkOutput("wrap_pc_4", out_pc_4, 32'd0);
      end
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("wrap_seen", 32'(seen), 32'd1);
    checkOutput("wrap_addr_top", (k < acked_addr.size()) ? acked_addr[k] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    checkOutput("wrap_addr_zero", (k + 1 < acked_addr.size()) ? acked_addr[k+1] : 32'hxxxx_xxxx, 32'd0);

    // Reset in the middle of an outstanding request
    lat_lo = 3;
    lat_hi = 3;
    for (int i = 0; i < 10 && !imem_req; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_req_before", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
    checkOutput("mid_rst_addr", imem_addr, RESET_PC);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);

    // Randomised traffic against the scoreboard
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 300; i++) begin
      rpc = $urandom();
`ifdef FETCH_ALIGN_CHECK_EN
      rpc[1:0] = 2'b00;
`endif
      applyStimulus($urandom_range(19, 0) == 0, rpc, $urandom_range(9, 0) < 7);
    end

    // Misaligned redirect
    lat_lo = 0;
    lat_hi = 0;
    for (int i = 0; i < 20 && imem_req; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mis_idle", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 32'h0000_1002, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("mis_fault", 32'(fault), 32'd1);
    repeat (10) begin
      checkOutput("mis_no_req", 32'(imem_req), 32'd0);
      checkOutput("mis_no_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("mis_fault_sticky", 32'(fault), 32'd1);
`else
    checkOutput("mis_req", 32'(imem_req), 32'd1);
    checkOutput("mis_addr", imem_addr, 32'h0000_1000);
    repeat (6) applyStimulus(1'b0, '0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-side owner of the program counter. It consumes the resolved next-PC that execute sends back on a redirect, and issues single-outstanding instruction-memory reads. Fetched words go into a small in-order buffer that feeds decode with `instr`, `pc` and `pc_4`. It sits between instruction memory and decode, and is the receiving end of the branch/jump redirect path.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: fetch buffer entries; legal values 2–4.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `redirect_valid`  in  1  execute has a taken branch or jump this cycle.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  read address; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle response strobe; valid only while `imem_req` is high.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `out_valid`  out  1  buffer head valid to decode.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head address.
- `out_pc_4`  out  32  `out_pc + 4`, modulo 2^32.
- `fault`  out  1  misaligned-redirect fault; exists only with the macro defined.

## Operation
- **State machine:** IDLE, FETCH, DISCARD, FAULT.
- **IDLE:** entered only from reset. Moves to FETCH after one cycle.
- **FETCH, issuing:**
  - Asserts `imem_req` with `imem_addr` = fetch PC when `count + outstanding < BUF_DEPTH`.
  - Keeps `imem_req` asserted until `imem_ack`.
  - At most one request outstanding.
- **FETCH, on `imem_ack` with no redirect:**
  - Pushes {`imem_rdata`, `imem_addr`} into the buffer.
  - Fetch PC becomes `imem_addr + 4`; it wraps from FFFF_FFFC to 0000_0000.
  - A new request may be issued in the next cycle.
- **Redirect:** when `redirect_valid` is high, in the same edge:
  - Flush the buffer (count becomes 0).
  - Fetch PC becomes `redirect_pc`.
  - An `out_ready` pop in that cycle is ignored.
- **Redirect with a request outstanding and no `imem_ack` that cycle:**
  - Go to DISCARD.
  - `imem_req` and the old `imem_addr` stay high until `imem_ack`.
  - That response is dropped, then return to FETCH.
- **Redirect coinciding with `imem_ack`:** the data is dropped and the state stays FETCH.
- **Redirect while in DISCARD:** only the fetch PC is updated; the state stays DISCARD.
- **Buffer:**
  - FIFO, push and pop allowed in the same cycle.
  - Pop on `out_valid && out_ready && !redirect_valid`.
  - `out_*` are driven from the head register (registered outputs, no combinational path from `imem_rdata`).
- **Width rules:** all PC arithmetic is 32-bit unsigned, and carry-out is discarded.

## Timing
- **Reset values:**
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `out_valid` = 0; `out_instr`, `out_pc` = 0; `out_pc_4` = 4.
  - `fault` = 0, state = IDLE.
- **Start-up:** first `imem_req` is in the 2nd cycle after `rst_n` deasserts.
- **Latency:** ack at edge N makes `out_valid` high after edge N (cycle N+1).
- **Redirect at cycle N, nothing outstanding:** `imem_req` with `redirect_pc` in cycle N+1.
- **Zero-wait memory:** `imem_ack` is allowed in the same cycle `imem_req` first rises. Sustained throughput is one instruction per 2 cycles.
- **Full buffer:** no request is issued. With `out_ready` held high, throughput is 1 instruction per 2 cycles.
- **Reset mid-operation:** `rst_n` low drops `imem_req` immediately, even with a request outstanding. Memory must also be reset.

## Configuration
- **Macro:** `FETCH_ALIGN_CHECK_EN`.
- **Defined:**
  - A redirect with `redirect_pc[1:0] != 0` enters FAULT and sets `fault`, which is sticky until reset.
  - The buffer is flushed.
  - After any outstanding ack is absorbed, no further requests are issued.
  - `out_valid` stays 0.
- **Undefined:**
  - No `fault` port.
  - `redirect_pc[1:0]` is forced to 0 before use.

## Test plan
- **Reset and start-up:** reset, `RESET_PC`=0x100, memory acks same cycle, `out_ready`=1 → fetch addresses 0x100, 0x104, 0x108; `out_pc_4`=0x104 alongside `out_pc`=0x100.
- **Backpressure:** `out_ready`=0 for 10 cycles → exactly `BUF_DEPTH` acks, then `imem_req` stays 0. Release → words come out in order and none are lost.
- **Redirect during outstanding request:** memory latency 3, redirect to 0x2000 one cycle after req to 0x108 → the 0x108 data is discarded. The next `imem_addr` is 0x2000, and the first `out_pc` after the redirect is 0x2000.
- **Simultaneous redirect, ack and pop:** redirect to 0x40 on the same cycle as `imem_ack` and `out_ready` → buffer empty next cycle, next request 0x40, no stale `out_valid`.
- **Wrap-around:** redirect to 0xFFFF_FFFC → next fetch address is 0x0000_0000; `out_pc_4` for that word is 0.
- **Misaligned redirect:** redirect to 0x1002 with the macro defined → `fault` is 1 the next cycle, no further `imem_req`, `out_valid` stays 0. Without the macro → fetch from 0x1000.
